// File: rtl/dc_token_ring_writer.sv
// Producer side of a dual-clock token-ring channel. The ring storage lives
// here. The writer publishes a one-hot write token and serves the word
// selected by the reader's one-hot pointer through a purely combinational mux.
module dc_token_ring_writer #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BUFFER_WIDTH = 8,
    parameter int unsigned LEVEL_WIDTH  = $clog2(BUFFER_WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [BUFFER_WIDTH-1:0] write_token_o,
    input  logic [BUFFER_WIDTH-1:0] read_pointer_i,
    output logic [DATA_WIDTH-1:0]   data_async_o,
    output logic [LEVEL_WIDTH-1:0]  level_o
);

    // Ring size reduced modulo 2**LEVEL_WIDTH. The wrapped occupancy then
    // comes out right in LEVEL_WIDTH-bit arithmetic.
    localparam logic [LEVEL_WIDTH-1:0] BW_MOD = LEVEL_WIDTH'(BUFFER_WIDTH);

    logic [BUFFER_WIDTH-1:0] write_token_q, write_token_d;
    logic [BUFFER_WIDTH-1:0] sync1_q, sync2_q;
    logic [BUFFER_WIDTH-1:0] rd_stable_q, rd_stable_d;
    logic [BUFFER_WIDTH-1:0] token_next;
    logic [DATA_WIDTH-1:0]   buffer_q [BUFFER_WIDTH];
    logic [DATA_WIDTH-1:0]   masked   [BUFFER_WIDTH];
    logic                    full;
    logic                    push;
    logic                    sync2_onehot;
    logic [LEVEL_WIDTH-1:0]  wr_idx, rd_idx;

    // Token advance, full detection and the pointer glitch filter
    always_comb begin
        token_next    = {write_token_q[BUFFER_WIDTH-2:0], write_token_q[BUFFER_WIDTH-1]};
        full          = (token_next == rd_stable_q);
        push          = valid_i && !full;
        write_token_d = push ? token_next : write_token_q;
        // Only a clean one-hot sample may update the stable pointer. A pointer
        // caught mid-transition is dropped, and the old value errs on the safe side.
        sync2_onehot  = (sync2_q != '0) &&
                        ((sync2_q & (sync2_q - BUFFER_WIDTH'(1))) == '0);
        rd_stable_d   = sync2_onehot ? sync2_q : rd_stable_q;
    end

    assign ready_o       = !full;
    assign write_token_o = write_token_q;

    // Token register, two-flop pointer synchronizer and stable pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_token_q <= BUFFER_WIDTH'(1);
            sync1_q       <= BUFFER_WIDTH'(1);
            sync2_q       <= BUFFER_WIDTH'(1);
            rd_stable_q   <= BUFFER_WIDTH'(1);
        end else begin
            write_token_q <= write_token_d;
            sync1_q       <= read_pointer_i;
            sync2_q       <= sync1_q;
            rd_stable_q   <= rd_stable_d;
        end
    end

    // Per-slot storage: a slot captures data only when the token flags it on a push
    for (genvar gi = 0; gi < BUFFER_WIDTH; gi++) begin : g_slot
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                buffer_q[gi] <= '0;
            end else if (push && write_token_q[gi]) begin
                buffer_q[gi] <= data_i;
            end
        end

        assign masked[gi] = buffer_q[gi] & {DATA_WIDTH{read_pointer_i[gi]}};
    end

    // Reader-facing AND-OR mux driven straight from the raw remote pointer
    always_comb begin
        data_async_o = '0;
        for (int unsigned i = 0; i < BUFFER_WIDTH; i++) begin
            data_async_o = data_async_o | masked[i];
        end
    end

    // One-hot to binary conversion of both pointers
    always_comb begin
        wr_idx = '0;
        rd_idx = '0;
        for (int unsigned i = 0; i < BUFFER_WIDTH; i++) begin
            if (write_token_q[i]) wr_idx = wr_idx | LEVEL_WIDTH'(i);
            if (rd_stable_q[i])   rd_idx = rd_idx | LEVEL_WIDTH'(i);
        end
    end

    // Occupancy as seen by the writer, modulo the ring size
    always_comb begin
        if (wr_idx >= rd_idx) begin
            level_o = wr_idx - rd_idx;
        end else begin
            level_o = wr_idx + BW_MOD - rd_idx;
        end
    end

endmodule
